// File: rtl/hwpe_stream_rr_arbiter_if.sv
// HWPE-Stream handshake bundle: valid/ready with data and byte strobes.
// The sink modport is the receiving side, the source modport the driving side.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport sink (
        input  valid,
        input  data,
        input  strb,
        output ready
    );

    modport source (
        output valid,
        output data,
        output strb,
        input  ready
    );
endinterface

// File: rtl/hwpe_stream_rr_arbiter.sv
// Round-robin arbiter sharing one HWPE-Stream sink among NB_IN requesters.
// A grant locks onto the winner so valid/data/strb stay stable under
// backpressure; the data and handshake path is purely combinational.
// Optional feature: define HWPE_STREAM_ARB_BURST_LOCK_EN to hold a grant for
// up to MAX_BURST beats; otherwise the arbiter re-arbitrates after every beat.
module hwpe_stream_rr_arbiter #(
    parameter int unsigned NB_IN      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               clear_i,
    input  logic [NB_IN-1:0]                   mask_i,
    hwpe_stream_intf_stream.sink               push [NB_IN-1:0],
    hwpe_stream_intf_stream.source             pop,
    output logic [NB_IN-1:0]                   grant_o,
    output logic                               locked_o,
    output logic [$clog2(MAX_BURST+1)-1:0]     burst_cnt_o
);
    localparam int unsigned PTR_W      = $clog2(NB_IN);
    localparam int unsigned CNT_W      = $clog2(MAX_BURST + 1);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
`ifdef HWPE_STREAM_ARB_BURST_LOCK_EN
    localparam int unsigned BURST_LIMIT = MAX_BURST;
`else
    localparam int unsigned BURST_LIMIT = 1;
`endif

    typedef enum logic {IDLE, GRANT} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NB_IN-1:0]      in_valid;
    logic [NB_IN-1:0]      in_ready;
    logic [DATA_WIDTH-1:0] in_data [NB_IN];
    logic [STRB_WIDTH-1:0] in_strb [NB_IN];
    logic [NB_IN-1:0]      eligible;

    logic [PTR_W-1:0] scan_idx;
    logic [PTR_W-1:0] win_idx;
    logic             win_found;
    logic [PTR_W-1:0] sel;
    logic             src_valid;
    logic             handshake;
    logic [CNT_W-1:0] cnt_inc;
    logic             limit_hit;

    // Interface arrays can only be indexed by constants, so flatten them here.
    for (genvar i = 0; i < NB_IN; i++) begin : g_flatten
        assign in_valid[i]   = push[i].valid;
        assign in_data[i]    = push[i].data;
        assign in_strb[i]    = push[i].strb;
        assign push[i].ready = in_ready[i];
    end

    assign eligible = in_valid & mask_i;

    // Circular search for the first eligible requester starting at rr_ptr_q.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = rr_ptr_q;
        for (int k = 0; k < NB_IN; k++) begin
            if (!win_found && eligible[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
            scan_idx = (scan_idx == PTR_W'(NB_IN - 1)) ? '0 : scan_idx + PTR_W'(1);
        end
    end

    // Source selection and combinational stream mux: locked source in GRANT.
    always_comb begin
        sel       = (state_q == GRANT) ? grant_q : win_idx;
        src_valid = (state_q == GRANT) ? in_valid[grant_q] : win_found;
        in_ready  = '0;
        if (state_q == GRANT || win_found) begin
            in_ready[sel] = pop.ready;
        end
    end

    assign pop.valid = src_valid;
    assign pop.data  = in_data[sel];
    assign pop.strb  = in_strb[sel];
    assign handshake = src_valid & pop.ready;

    assign cnt_inc   = (cnt_q == CNT_W'(MAX_BURST)) ? cnt_q : cnt_q + CNT_W'(1);
    assign limit_hit = (cnt_inc >= CNT_W'(BURST_LIMIT));

    // Next-state logic: lock on a winner, count beats, release on limit or valid drop.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    rr_ptr_d = (win_idx == PTR_W'(NB_IN - 1)) ? '0 : win_idx + PTR_W'(1);
                    // A single-beat limit completes in this cycle, so no lock is needed.
                    if (!(handshake && BURST_LIMIT == 1)) begin
                        state_d = GRANT;
                        grant_d = win_idx;
                        cnt_d   = handshake ? CNT_W'(1) : '0;
                    end
                end
            end
            GRANT: begin
                if (!in_valid[grant_q]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (handshake) begin
                    if (limit_hit) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant bookkeeping registers; clear_i has the same effect as reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // the pre-edge values regardless of statement order.
        if (!rst_ni) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clear_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Status outputs derived from the registered grant state.
    always_comb begin
        grant_o = '0;
        if (state_q == GRANT) begin
            grant_o[grant_q] = 1'b1;
        end
    end

    assign locked_o    = (state_q == GRANT);
    assign burst_cnt_o = cnt_q;

endmodule

// File: tb/tb_hwpe_stream_rr_arbiter.sv
// Directed testbench for hwpe_stream_rr_arbiter (NB_IN=4, MAX_BURST=4).
// Expected sequences differ with HWPE_STREAM_ARB_BURST_LOCK_EN and are
// selected with the same macro.
module tb_hwpe_stream_rr_arbiter;
    localparam int unsigned NB_IN      = 4;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned MAX_BURST  = 4;
    localparam int unsigned CNT_W      = $clog2(MAX_BURST + 1);

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic [NB_IN-1:0] mask;
    logic [NB_IN-1:0] in_valid;
    logic [NB_IN-1:0] in_ready;
    logic             pop_ready;
    logic             pop_valid;
    logic [31:0]      pop_data;
    logic [3:0]       pop_strb;
    logic [NB_IN-1:0] grant;
    logic             locked;
    logic [CNT_W-1:0] burst_cnt;

    int checks = 0;
    int errors = 0;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DATA_WIDTH)) push [NB_IN-1:0] ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DATA_WIDTH)) pop ();

    for (genvar g = 0; g < NB_IN; g++) begin : g_req
        assign push[g].valid = in_valid[g];
        assign push[g].data  = 32'hC0DE_0000 + 32'(g);
        assign push[g].strb  = '1;
        assign in_ready[g]   = push[g].ready;
    end

    assign pop.ready = pop_ready;
    assign pop_valid = pop.valid;
    assign pop_data  = pop.data;
    assign pop_strb  = pop.strb;

    hwpe_stream_rr_arbiter #(
        .NB_IN      (NB_IN),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .mask_i      (mask),
        .push        (push),
        .pop         (pop),
        .grant_o     (grant),
        .locked_o    (locked),
        .burst_cnt_o (burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    // Advance one clock; inputs change and registered outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        in_valid = '0;
        clear    = 1'b1;
        cyc();
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", pop_valid); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b want 0000", grant); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked: got %b want 0", locked); end
        checks++; if (burst_cnt !== '0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", burst_cnt); end
        cyc();
        #2 rst_n = 1'b1;
        cyc();
        checks++; if (grant !== 4'b0000 || locked !== 1'b0) begin errors++; $display("FAIL rst_after: grant %b locked %b want 0000/0", grant, locked); end
    endtask

    task automatic test_full_burst();
        int         exp_req [9];
        int         exp_cnt [9];
        logic [3:0] exp_gnt [9];
`ifdef HWPE_STREAM_ARB_BURST_LOCK_EN
        exp_req = '{0, 0, 0, 0, 2, 2, 2, 2, 0};
        exp_cnt = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
        exp_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001};
`else
        exp_req = '{0, 2, 0, 2, 0, 2, 0, 2, 0};
        exp_cnt = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_gnt = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
`endif
        do_clear();
        mask      = 4'b1111;
        pop_ready = 1'b1;
        in_valid  = 4'b0101;
        for (int i = 0; i < 9; i++) begin
            #1;
            checks++; if (pop_valid !== 1'b1) begin errors++; $display("FAIL burst_valid[%0d]: got %b want 1", i, pop_valid); end
            checks++; if (pop_data !== word(exp_req[i])) begin errors++; $display("FAIL burst_data[%0d]: got %h want %h", i, pop_data, word(exp_req[i])); end
            checks++; if (in_ready !== 4'(1 << exp_req[i])) begin errors++; $display("FAIL burst_ready[%0d]: got %b want %b", i, in_ready, 4'(1 << exp_req[i])); end
            cyc();
            checks++; if (burst_cnt !== CNT_W'(exp_cnt[i])) begin errors++; $display("FAIL burst_cnt[%0d]: got %0d want %0d", i, burst_cnt, exp_cnt[i]); end
            checks++; if (grant !== exp_gnt[i]) begin errors++; $display("FAIL burst_grant[%0d]: got %b want %b", i, grant, exp_gnt[i]); end
        end
        checks++; if (pop_strb !== 4'hF) begin errors++; $display("FAIL burst_strb: got %h want f", pop_strb); end
    endtask

    task automatic test_backpressure();
        do_clear();
        mask      = 4'b1111;
        pop_ready = 1'b0;
        in_valid  = 4'b0010;
        #1;
        checks++; if (pop_valid !== 1'b1 || pop_data !== word(1)) begin errors++; $display("FAIL bp_first: valid %b data %h want 1/%h", pop_valid, pop_data, word(1)); end
        cyc();
        in_valid = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL bp_grant[%0d]: got %b want 0010", i, grant); end
            #1;
            checks++; if (pop_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, pop_valid); end
            checks++; if (pop_data !== word(1)) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, pop_data, word(1)); end
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, in_ready); end
            cyc();
        end
        pop_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b want 0010", in_ready); end
        cyc();
`ifdef HWPE_STREAM_ARB_BURST_LOCK_EN
        checks++; if (grant !== 4'b0010 || burst_cnt !== CNT_W'(1)) begin errors++; $display("FAIL bp_after: grant %b cnt %0d want 0010/1", grant, burst_cnt); end
        #1;
        checks++; if (pop_data !== word(1)) begin errors++; $display("FAIL bp_next_data: got %h want %h", pop_data, word(1)); end
`else
        checks++; if (grant !== 4'b0000 || burst_cnt !== '0) begin errors++; $display("FAIL bp_after: grant %b cnt %0d want 0000/0", grant, burst_cnt); end
        #1;
        checks++; if (pop_data !== word(0)) begin errors++; $display("FAIL bp_next_data: got %h want %h", pop_data, word(0)); end
`endif
        cyc();
    endtask

    task automatic test_early_release();
        do_clear();
        mask      = 4'b1111;
        pop_ready = 1'b1;
        in_valid  = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (pop_valid !== 1'b1 || pop_data !== word(3)) begin errors++; $display("FAIL early_beat[%0d]: valid %b data %h want 1/%h", i, pop_valid, pop_data, word(3)); end
            cyc();
        end
`ifdef HWPE_STREAM_ARB_BURST_LOCK_EN
        checks++; if (burst_cnt !== CNT_W'(2) || grant !== 4'b1000) begin errors++; $display("FAIL early_cnt: cnt %0d grant %b want 2/1000", burst_cnt, grant); end
        in_valid = 4'b0001;
        #1;
        checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL early_bubble: got %b want 0", pop_valid); end
        checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL early_bubble_ready: got %b want 0", in_ready[0]); end
        cyc();
        checks++; if (locked !== 1'b0 || burst_cnt !== '0) begin errors++; $display("FAIL early_released: locked %b cnt %0d want 0/0", locked, burst_cnt); end
        #1;
        checks++; if (pop_valid !== 1'b1 || pop_data !== word(0)) begin errors++; $display("FAIL early_wrap: valid %b data %h want 1/%h", pop_valid, pop_data, word(0)); end
`else
        checks++; if (burst_cnt !== '0 || locked !== 1'b0) begin errors++; $display("FAIL early_cnt: cnt %0d locked %b want 0/0", burst_cnt, locked); end
        in_valid = 4'b0001;
        #1;
        checks++; if (pop_valid !== 1'b1 || pop_data !== word(0)) begin errors++; $display("FAIL early_wrap: valid %b data %h want 1/%h", pop_valid, pop_data, word(0)); end
`endif
        cyc();
    endtask

    task automatic test_mask_clear();
        int exp_mask [12];
        int exp_clr  [6];
        int clr_at;
`ifdef HWPE_STREAM_ARB_BURST_LOCK_EN
        exp_mask = '{0, 0, 0, 0, 1, 1, 1, 1, 3, 3, 3, 3};
        exp_clr  = '{0, 0, 0, 0, 1, 1};
        clr_at   = 5;
`else
        exp_mask = '{0, 1, 3, 0, 1, 3, 0, 1, 3, 0, 1, 3};
        exp_clr  = '{0, 1, 3, 0, 1, 1};
        clr_at   = 4;
`endif
        do_clear();
        mask      = 4'b1011;
        pop_ready = 1'b1;
        in_valid  = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            #1;
            checks++; if (pop_data !== word(exp_mask[i])) begin errors++; $display("FAIL mask_data[%0d]: got %h want %h", i, pop_data, word(exp_mask[i])); end
            checks++; if (in_ready[2] !== 1'b0) begin errors++; $display("FAIL mask_ready2[%0d]: got %b want 0", i, in_ready[2]); end
            cyc();
        end
        do_clear();
        in_valid = 4'b1111;
        for (int i = 0; i <= clr_at; i++) begin
            if (i == clr_at) clear = 1'b1;
            #1;
            checks++; if (pop_data !== word(exp_clr[i])) begin errors++; $display("FAIL clr_data[%0d]: got %h want %h", i, pop_data, word(exp_clr[i])); end
            cyc();
        end
        clear = 1'b0;
        checks++; if (locked !== 1'b0 || grant !== 4'b0000 || burst_cnt !== '0) begin errors++; $display("FAIL clr_state: locked %b grant %b cnt %0d want 0/0000/0", locked, grant, burst_cnt); end
        #1;
        checks++; if (pop_data !== word(0)) begin errors++; $display("FAIL clr_restart: got %h want %h", pop_data, word(0)); end
        cyc();
    endtask

    task automatic test_back_to_back();
        int exp_req [8];
`ifdef HWPE_STREAM_ARB_BURST_LOCK_EN
        exp_req = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp_req = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        do_clear();
        mask      = 4'b1111;
        pop_ready = 1'b1;
        in_valid  = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (pop_valid !== 1'b1 || pop_data !== word(exp_req[i])) begin errors++; $display("FAIL b2b_data[%0d]: valid %b data %h want 1/%h", i, pop_valid, pop_data, word(exp_req[i])); end
            checks++; if (in_ready !== 4'(1 << exp_req[i])) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, in_ready, 4'(1 << exp_req[i])); end
            cyc();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        mask      = 4'b1111;
        in_valid  = '0;
        pop_ready = 1'b1;
        test_reset();
        test_full_burst();
        test_backpressure();
        test_early_release();
        test_mask_clear();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_rr_arbiter.md
# hwpe_stream_rr_arbiter

Round-robin arbiter that shares one HWPE-Stream sink, typically the `push` side of a stream FIFO, among `NB_IN` requester streams. Each grant locks onto the winning requester for a burst of up to `MAX_BURST` beats. The lock keeps `valid`, `data` and `strb` stable under backpressure. Every requester gets fair access. The block sits between the streamer source ports and the shared FIFO in the HWPE datapath. Its `valid`/`ready`/data path is combinational; only the grant bookkeeping is sequential.

## Interface
- `NB_IN`, 4: number of requester streams; must be ≥ 2.
- `DATA_WIDTH`, 32: stream data width; `strb` is `DATA_WIDTH/8`.
- `MAX_BURST`, 8: maximum beats per grant; must be ≥ 1.

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `clear_i`  in  1  synchronous clear; same effect as reset.
- `mask_i`  in  `NB_IN`  per-requester arbitration enable; bit low means the requester is never selected.
- `push[NB_IN-1:0]`  `hwpe_stream_intf_stream.sink`  `DATA_WIDTH`  requester streams.
- `pop`  `hwpe_stream_intf_stream.source`  `DATA_WIDTH`  arbitrated output, to the FIFO `push`.
- `grant_o`  out  `NB_IN`  one-hot registered grant; all zero when IDLE.
- `locked_o`  out  1  high in state GRANT.
- `burst_cnt_o`  out  `$clog2(MAX_BURST+1)`  beats transferred in the current grant.

## Operation
- **State:** FSM with states IDLE and GRANT, plus registers `grant_q`, `rr_ptr_q` (index, `$clog2(NB_IN)` bits) and `cnt_q`.
- **Eligibility:** requester i is eligible when `push[i].valid & mask_i[i]`.
- **Winner w:** the first eligible index, searching circularly from `rr_ptr_q` upward and wrapping at `NB_IN-1 → 0`.
- **IDLE, nothing eligible:** `pop.valid=0`; all `push[i].ready=0`.
- **IDLE, w exists:**
  - `pop.valid/data/strb` come from `push[w]`; `push[w].ready = pop.ready`; all other readies are 0.
  - Next state is GRANT with `grant_q=w` and `rr_ptr_q = (w+1) mod NB_IN`.
  - `cnt_q` = 1 if a handshake occurred this cycle, else 0.
  - Exception: if a handshake occurs and the effective burst limit is 1, the FSM stays in IDLE (`grant_q` and `cnt_q` unchanged) and only `rr_ptr_q` updates.
- **GRANT:**
  - The source is `push[grant_q]`; `mask_i` is ignored, so there is no pre-emption.
  - On each handshake, `cnt_q` increments.
  - Release to IDLE when a handshake brings the count to the effective burst limit.
  - Release to IDLE when `push[grant_q].valid==0`. That cycle shows `pop.valid=0` and costs one bubble.
  - Never release while `pop.valid & ~pop.ready`. This preserves HWPE-Stream stability.
- **Arithmetic:** `cnt_q` saturates at `MAX_BURST`; `cnt_q` clears on entry to IDLE.
- **Reset / clear:** state IDLE, `grant_q=0`, `rr_ptr_q=0`, `cnt_q=0`.
  - Outputs after reset/clear: `grant_o=0`, `locked_o=0`, `burst_cnt_o=0`, `pop.valid=0` (when no eligible requester).
  - Clear during a burst aborts the burst; the next cycle re-arbitrates from index 0.

## Timing
- Zero-cycle latency on the data and handshake paths (combinational mux).
- `grant_o` and `locked_o` update one cycle after the arbitration decision.
- A release caused by the burst limit gives back-to-back transfers: the IDLE cycle after release arbitrates and transfers with no bubble.
- A release caused by `valid` dropping costs exactly one `pop.valid=0` cycle.
- A requester that raises `valid` while another holds the grant waits at most `(NB_IN-1)·(MAX_BURST+1)` cycles, given `pop.ready` stays high.
- Simultaneous events:
  - A handshake and the burst limit in the same cycle: release.
  - `valid` drop: it can only happen in a cycle with no handshake, so there is no conflict.

## Configuration
- `HWPE_STREAM_ARB_BURST_LOCK_EN` defined: effective burst limit = `MAX_BURST`.
- Undefined: effective burst limit = 1.
  - Re-arbitration happens after every beat (pure per-beat round-robin).
  - GRANT is entered only to hold a stalled beat.
  - `burst_cnt_o` stays 0.

## Test plan
- **Reset values:** reset with all `valid=0` → `pop.valid=0`, `grant_o=0`, `locked_o=0`, `burst_cnt_o=0`.
- **Full burst:** macro on, `MAX_BURST=4`, requesters 0 and 2 continuously valid, `pop.ready=1` → 4 beats from 0, then 4 beats from 2, then 0 again; no bubble between bursts.
- **Backpressure:** requester 1 granted, `pop.ready=0` for 5 cycles while requester 0 becomes valid → `pop.data` stays requester 1's word with `pop.valid=1` throughout; `grant_o=4'b0010` holds.
- **Early release:** requester 3 drops `valid` after 2 of 8 beats → exactly one `pop.valid=0` cycle, then the next eligible requester wraps to 0; `burst_cnt_o` shows 2 before release.
- **Mask and clear:** `mask_i=4'b1011` with all valid → requester 2 is never granted. `clear_i` pulsed mid-burst → next cycle `locked_o=0` and arbitration restarts at index 0.
- **Macro off:** all 4 valid, `pop.ready=1` → beats alternate 0,1,2,3,0 every cycle.
